// File: rtl/bk_sub32_pipe.sv
// Two-stage pipelined subtractor: diff = a - b - bin, computed as a + ~b + ~bin with
// Brent-Kung prefix halves. Define SUB_SAT_EN to clamp diff on signed overflow.
module bk_sub32_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int H = WIDTH / 2;

    // Returns {carry_out, sum} of x + y + cin using an up-sweep / down-sweep prefix tree.
    function automatic logic [H:0] bk_add(input logic [H-1:0] x,
                                          input logic [H-1:0] y,
                                          input logic         cin);
        logic [H-1:0] g;
        logic [H-1:0] p;
        logic [H-1:0] p0;
        g    = x & y;
        p    = x ^ y;
        p0   = p;
        g[0] = g[0] | (p[0] & cin);
        for (int k = 0; (1 << k) < H; k++) begin
            for (int i = 0; i < H; i++) begin
                if ((i + 1) % (2 << k) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << k)]);
                    p[i] = p[i] & p[i - (1 << k)];
                end
            end
        end
        for (int k = $clog2(H); k >= 0; k--) begin
            for (int i = 0; i < H; i++) begin
                if (i >= 3 * (1 << k) - 1 && (i + 1) % (2 << k) == (1 << k)) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << k)]);
                end
            end
        end
        return {g[H-1], p0 ^ {g[H-2:0], cin}};
    endfunction

    logic             v1_q, v1_d;
    logic [H-1:0]     lo_q;
    logic             c_lo_q;
    logic [H-1:0]     a_hi_q;
    logic [H-1:0]     nb_hi_q;
    logic [TAG_W-1:0] tag1_q;

    logic             v2_q, v2_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [TAG_W-1:0] tag2_q;

    logic             adv2, accept, move;
    logic [H:0]       lo_res, hi_res;
    logic [WIDTH-1:0] raw;
    logic             a_msb, b_msb;

    assign adv2     = !v2_q || out_ready;
    assign in_ready = !v1_q || adv2;
    assign accept   = in_valid && in_ready;
    assign move     = v1_q && adv2;

    assign v1_d = accept || (v1_q && !adv2);
    assign v2_d = move || (v2_q && !out_ready);

    assign lo_res = bk_add(a[H-1:0], ~b[H-1:0], ~bin);
    assign hi_res = bk_add(a_hi_q, nb_hi_q, c_lo_q);
    assign raw    = {hi_res[H-1:0], lo_q};
    assign a_msb  = a_hi_q[H-1];
    assign b_msb  = ~nb_hi_q[H-1];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        diff_d = raw;
        bout_d = ~hi_res[H];
        ovf_d  = (a_msb != b_msb) && (raw[WIDTH-1] != a_msb);
`ifdef SUB_SAT_EN
        if (ovf_d) begin
            diff_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        zero_d = (diff_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            tag2_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (move) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
                tag2_q <= tag1_q;
            end
        end
    end

    // NOTE: stage-1 payload is qualified by v1_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lo_q    <= lo_res[H-1:0];
            c_lo_q  <= lo_res[H];
            a_hi_q  <= a[WIDTH-1:H];
            nb_hi_q <= ~b[WIDTH-1:H];
            tag1_q  <= in_tag;
        end
    end

    assign out_valid = v2_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_tag   = tag2_q;

endmodule
